// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : fetch/data requester and memory-port signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Fetch requester (port I)
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  // Load/store requester (port D)
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  // Shared memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  // The arbiter is the master of the memory port.
  modport master (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy
  );

  // Core requesters plus memory, seen from outside the arbiter.
  modport slave (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch (I) and load/store (D)
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate winner on contention. Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_port_arbiter_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  owner;
  logic                  any_req;
  logic                  pick_d;

  logic                  i_gnt_q;
  logic                  i_rvalid_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic                  d_gnt_q;
  logic                  d_rvalid_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  always_comb begin
    any_req = bus.i_req | bus.d_req;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner;

  // On contention the port that did not win last time takes the port.
  always_comb begin
    pick_d = bus.d_req;
    if (bus.i_req && bus.d_req) begin
      pick_d = (last_owner == OWN_I);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_D;
    end else if ((state == ST_IDLE) && any_req) begin
      last_owner <= pick_d;
    end
  end
`else
  // D outranks I: a pending load/store belongs to an already-fetched instruction.
  always_comb begin
    pick_d = bus.d_req;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_ready) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_rvalid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_I;
      i_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state      <= state_nxt;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner       <= pick_d ? OWN_D : OWN_I;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
            mem_we_q    <= pick_d & bus.d_we;
            mem_wdata_q <= pick_d ? bus.d_wdata : '0;
            i_gnt_q     <= ~pick_d;
            d_gnt_q     <= pick_d;
          end
        end
        ST_REQ: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
          end
        end
        ST_RESP: begin
          if (bus.mem_rvalid) begin
            if (owner == OWN_D) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= bus.mem_rdata;
            end
          end
        end
        default: begin
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_gnt     = i_gnt_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed + randomized self-checking bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: last data each requester saw, and last contention winner.
  logic [DW-1:0] exp_i_rdata;
  logic [DW-1:0] exp_d_rdata;
  bit            model_last_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pick_d(input bit ireq, input bit dreq);
    if (ireq && dreq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return !model_last_d;
`else
      return 1'b1;
`endif
    end
    return dreq;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_i_gnt"},     bus.i_gnt,     0);
    check({tag, "_i_rvalid"},  bus.i_rvalid,  0);
    check({tag, "_i_rdata"},   bus.i_rdata,   0);
    check({tag, "_d_gnt"},     bus.d_gnt,     0);
    check({tag, "_d_rvalid"},  bus.d_rvalid,  0);
    check({tag, "_d_rdata"},   bus.d_rdata,   0);
    check({tag, "_mem_req"},   bus.mem_req,   0);
    check({tag, "_mem_we"},    bus.mem_we,    0);
    check({tag, "_mem_addr"},  bus.mem_addr,  0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_busy"},      bus.busy,      0);
  endtask

  // One full transaction starting in IDLE with the requests already driven.
  task automatic txn(input int ready_wait, input int rvalid_wait,
                     input logic [DW-1:0] rd, input bit drop);
    bit            wd;
    logic [AW-1:0] ea;
    bit            ewe;
    logic [DW-1:0] ewd;
    wd  = model_pick_d(bus.i_req, bus.d_req);
    ea  = wd ? bus.d_addr : bus.i_addr;
    ewe = wd & bus.d_we;
    ewd = (wd && bus.d_we) ? bus.d_wdata : (wd ? bus.d_wdata : '0);
    model_last_d = wd;
    check("idle_busy", bus.busy, 0);
    step();
    check("gnt_i",     bus.i_gnt,     !wd);
    check("gnt_d",     bus.d_gnt,     wd);
    check("req_up",    bus.mem_req,   1);
    check("req_addr",  bus.mem_addr,  ea);
    check("req_we",    bus.mem_we,    ewe);
    check("req_wdata", bus.mem_wdata, ewd);
    check("req_busy",  bus.busy,      1);
    if (drop) begin
      if (wd) begin
        bus.d_req   = 1'b0;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end else begin
        bus.i_req  = 1'b0;
        bus.i_addr = $urandom;
      end
    end
    for (int w = 0; w < ready_wait; w++) begin
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      step();
      check("wait_req",   bus.mem_req,   1);
      check("wait_addr",  bus.mem_addr,  ea);
      check("wait_we",    bus.mem_we,    ewe);
      check("wait_wdata", bus.mem_wdata, ewd);
      check("wait_gnt",   {bus.i_gnt, bus.d_gnt}, 0);
      check("wait_rv",    {bus.i_rvalid, bus.d_rvalid}, 0);
    end
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'($urandom_range(0, 1));
    step();
    check("resp_req",  bus.mem_req, 0);
    check("resp_busy", bus.busy,    1);
    check("resp_gnt",  {bus.i_gnt, bus.d_gnt}, 0);
    check("resp_rv",   {bus.i_rvalid, bus.d_rvalid}, 0);
    for (int w = 0; w < rvalid_wait; w++) begin
      bus.mem_ready  = 1'($urandom_range(0, 1));
      bus.mem_rvalid = 1'b0;
      step();
      check("rwait_busy", bus.busy, 1);
      check("rwait_rv",   {bus.i_rvalid, bus.d_rvalid}, 0);
      check("rwait_req",  bus.mem_req, 0);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    bus.mem_ready  = 1'($urandom_range(0, 1));
    step();
    if (wd) exp_d_rdata = ewe ? '0 : rd;
    else    exp_i_rdata = rd;
    check("done_i_rvalid", bus.i_rvalid, !wd);
    check("done_d_rvalid", bus.d_rvalid, wd);
    check("done_i_rdata",  bus.i_rdata,  exp_i_rdata);
    check("done_d_rdata",  bus.d_rdata,  exp_d_rdata);
    check("done_busy",     bus.busy,     0);
    check("done_req",      bus.mem_req,  0);
    bus.mem_rvalid = 1'b0;
    bus.mem_ready  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.i_req      = 1'b0;
    bus.i_addr     = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    exp_i_rdata    = '0;
    exp_d_rdata    = '0;
    model_last_d   = 1'b1;

    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle_noreq");

    // Fetch only
    bus.i_addr = 32'h8000_0000;
    bus.i_req  = 1'b1;
    txn(0, 0, 32'h0010_0073, 1'b1);

    // Store with memory back-pressure
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_0100;
    bus.d_wdata = 32'hDEAD_BEEF;
    txn(3, 0, 32'h5A5A_5A5A, 1'b1);

    // Contention with both requests held
    bus.d_we   = 1'b0;
    bus.i_addr = 32'h0000_2000;
    bus.d_addr = 32'h0000_3000;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] rd;
      rd = model_pick_d(bus.i_req, bus.d_req) ? 32'h22 : 32'h11;
      txn(0, k % 2, rd, 1'b0);
    end
    bus.d_req = 1'b0;
    txn(0, 0, 32'h33, 1'b1);

    // Reset during RESP; the late response must be dropped
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_4000;
    step();
    check("rst_mid_gnt", bus.i_gnt, 1);
    bus.i_req     = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    check("rst_mid_resp", bus.busy, 1);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    step();
    check_all_zero("rst_mid");
    rst          = 1'b0;
    model_last_d = 1'b1;
    exp_i_rdata  = '0;
    exp_d_rdata  = '0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hABCD_0123;
    step();
    check("late_rvalid_i", bus.i_rvalid, 0);
    check("late_rdata_i",  bus.i_rdata,  0);
    check("late_busy",     bus.busy,     0);
    bus.mem_rvalid = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!bus.i_req && $urandom_range(0, 1) == 1) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      if (!bus.d_req && $urandom_range(0, 1) == 1) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      if (!bus.i_req && !bus.d_req) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
